// File: rtl/bram_tdp_be.sv
// True dual-port RAM with per-byte write enables, 1- or 2-cycle read latency,
// configurable read-during-write, cross-port collision resolution and post-reset clear.
module bram_tdp_be #(
    parameter int WADDR      = 10,
    parameter int WDATA      = 32,
    parameter int WBYTE      = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                     pi_clk,
    input  logic                     pi_rst,
    // Port A
    input  logic                     pi_ena,
    input  logic [WDATA/WBYTE-1:0]   pi_wea,
    input  logic [WADDR-1:0]         pi_addra,
    input  logic [WDATA-1:0]         pi_dia,
    output logic [WDATA-1:0]         po_doa,
    output logic                     po_valida,
    // Port B
    input  logic                     pi_enb,
    input  logic [WDATA/WBYTE-1:0]   pi_web,
    input  logic [WADDR-1:0]         pi_addrb,
    input  logic [WDATA-1:0]         pi_dib,
    output logic [WDATA-1:0]         po_dob,
    output logic                     po_validb,
    // Status
    output logic                     po_collision,
    output logic                     po_init_busy,
    output logic                     po_init_state
);

    // Handshake: an access is accepted on any rising edge where en=1 and the
    // clear sweep is idle; there is no back-pressure. po_validX is high for
    // exactly one cycle, RD_LATENCY edges after the accepting edge, whenever that
    // access produces read data.

    localparam int NBE   = WDATA / WBYTE;
    localparam int DEPTH = 2 ** WADDR;

    if (WDATA % WBYTE != 0) begin : g_bad_wbyte
        $error("bram_tdp_be: WDATA must be a multiple of WBYTE");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("bram_tdp_be: RD_LATENCY must be 1 or 2");
    end
    if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_bad_rdw
        $error("bram_tdp_be: RDW_MODE must be 0, 1 or 2");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } init_state_t;

    init_state_t        state;
    init_state_t        state_nxt;
    logic [WADDR-1:0]   clr_addr;
    logic               busy;

    logic [WDATA-1:0]   mem [DEPTH];

    logic               en_a, en_b;
    logic               wr_a, wr_b;
    logic               same_addr;
    logic               collide;
    logic [WDATA-1:0]   old_a, old_b;
    logic [WDATA-1:0]   final_a, final_b;
    logic               take_a, take_b;
    logic [WDATA-1:0]   word_a, word_b;

    logic [WDATA-1:0]   doa_s1, dob_s1;
    logic               va_s1, vb_s1;

    // ------------------------------------------------------------------
    // Init clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            state    <= (INIT_CLEAR != 0) ? S_CLEAR : S_IDLE;
            clr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) begin
                clr_addr <= clr_addr + WADDR'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clr_addr == {WADDR{1'b1}}) state_nxt = S_IDLE;
            default: state_nxt = state;
        endcase
    end

    assign busy          = (state == S_CLEAR);
    assign po_init_busy  = busy;
    assign po_init_state = logic'(state);

    // ------------------------------------------------------------------
    // Access qualification and collision detect
    // ------------------------------------------------------------------
    assign en_a      = pi_ena & ~busy;
    assign en_b      = pi_enb & ~busy;
    assign wr_a      = en_a & (|pi_wea);
    assign wr_b      = en_b & (|pi_web);
    assign same_addr = (pi_addra == pi_addrb);
    assign collide   = en_a & en_b & same_addr & (wr_a | wr_b);

    assign old_a = mem[pi_addra];
    assign old_b = mem[pi_addrb];

    // Word each port leaves in memory; on a shared address both resolve to the
    // same value with port A owning any lane both ports write.
    always_comb begin
        final_a = old_a;
        final_b = old_b;
        for (int i = 0; i < NBE; i++) begin
            if (wr_b && pi_web[i] && same_addr) final_a[i*WBYTE +: WBYTE] = pi_dib[i*WBYTE +: WBYTE];
            if (wr_a && pi_wea[i])              final_a[i*WBYTE +: WBYTE] = pi_dia[i*WBYTE +: WBYTE];
            if (wr_b && pi_web[i])              final_b[i*WBYTE +: WBYTE] = pi_dib[i*WBYTE +: WBYTE];
            if (wr_a && pi_wea[i] && same_addr) final_b[i*WBYTE +: WBYTE] = pi_dia[i*WBYTE +: WBYTE];
        end
    end

    // ------------------------------------------------------------------
    // Memory array (never reset; the clear sweep zeroes it instead)
    // ------------------------------------------------------------------
    always_ff @(posedge pi_clk) begin
        if (busy) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr_b) mem[pi_addrb] <= final_b;
            if (wr_a) mem[pi_addra] <= final_a;
        end
    end

    // ------------------------------------------------------------------
    // Read-during-write selection and first output stage
    // ------------------------------------------------------------------
    always_comb begin
        take_a = en_a & (~wr_a | (RDW_MODE != 2));
        take_b = en_b & (~wr_b | (RDW_MODE != 2));
        word_a = (wr_a && RDW_MODE == 1) ? final_a : old_a;
        word_b = (wr_b && RDW_MODE == 1) ? final_b : old_b;
    end

    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            doa_s1       <= '0;
            dob_s1       <= '0;
            va_s1        <= 1'b0;
            vb_s1        <= 1'b0;
            po_collision <= 1'b0;
        end else begin
            va_s1        <= take_a;
            vb_s1        <= take_b;
            po_collision <= collide;
            if (take_a) doa_s1 <= word_a;
            if (take_b) dob_s1 <= word_b;
        end
    end

    // ------------------------------------------------------------------
    // Optional second output stage
    // ------------------------------------------------------------------
    if (RD_LATENCY == 2) begin : g_lat2
        logic [WDATA-1:0] doa_s2, dob_s2;
        logic             va_s2, vb_s2;

        always_ff @(posedge pi_clk or posedge pi_rst) begin
            if (pi_rst) begin
                doa_s2 <= '0;
                dob_s2 <= '0;
                va_s2  <= 1'b0;
                vb_s2  <= 1'b0;
            end else begin
                va_s2 <= va_s1;
                vb_s2 <= vb_s1;
                if (va_s1) doa_s2 <= doa_s1;
                if (vb_s1) dob_s2 <= dob_s1;
            end
        end

        assign po_doa    = doa_s2;
        assign po_dob    = dob_s2;
        assign po_valida = va_s2;
        assign po_validb = vb_s2;
    end else begin : g_lat1
        assign po_doa    = doa_s1;
        assign po_dob    = dob_s1;
        assign po_valida = va_s1;
        assign po_validb = vb_s1;
    end

endmodule

// File: tb/tb_bram_tdp_be.sv
// Randomized scoreboard bench for bram_tdp_be: four instances covering both read
// latencies and all read-during-write modes share one stimulus stream.
module tb_bram_tdp_be;

  localparam int WADDR = 4;
  localparam int WDATA = 32;
  localparam int WBYTE = 8;
  localparam int NBE   = WDATA / WBYTE;
  localparam int DEPTH = 2 ** WADDR;
  localparam int NI    = 4;
  localparam int NCH   = 2 * NI;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic             ena, enb;
  logic [NBE-1:0]   wea, web;
  logic [WADDR-1:0] addra, addrb;
  logic [WDATA-1:0] dia, dib;

  logic [WDATA-1:0] doa [NI];
  logic [WDATA-1:0] dob [NI];
  logic             valida [NI];
  logic             validb [NI];
  logic             col    [NI];
  logic             busy   [NI];
  logic             st     [NI];

  function automatic int lat_of(int g);
    return 1 + (g % 2);
  endfunction

  function automatic int mode_of(int g);
    return g % 3;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bram_tdp_be #(
      .WADDR(WADDR), .WDATA(WDATA), .WBYTE(WBYTE),
      .RD_LATENCY(1 + (g % 2)), .RDW_MODE(g % 3), .INIT_CLEAR(1)
    ) u_dut (
      .pi_clk(clk), .pi_rst(rst),
      .pi_ena(ena), .pi_wea(wea), .pi_addra(addra), .pi_dia(dia),
      .po_doa(doa[g]), .po_valida(valida[g]),
      .pi_enb(enb), .pi_web(web), .pi_addrb(addrb), .pi_dib(dib),
      .po_dob(dob[g]), .po_validb(validb[g]),
      .po_collision(col[g]), .po_init_busy(busy[g]), .po_init_state(st[g])
    );
  end

  // ---------------- reference model + scoreboard ----------------
  logic [WDATA-1:0] model_mem [DEPTH];
  int               rel_cyc = 0;
  logic [WDATA-1:0] exp_q    [NCH][$];
  int               due_q    [NCH][$];
  logic [WDATA-1:0] last_exp [NCH];
  bit               exp_col  [int];
  int               n_checks = 0;
  int               n_pass   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // The memory is busy for DEPTH cycles counted from reset release.
  function automatic bit busy_model(int c);
    return (c - rel_cyc) < DEPTH;
  endfunction

  function automatic void expect_port(int ch, int g, bit en, bit wr,
                                      logic [WDATA-1:0] old_w, logic [WDATA-1:0] new_w, int c);
    if (!en) return;
    if (wr && mode_of(g) == 2) return;
    exp_q[ch].push_back((wr && mode_of(g) == 1) ? new_w : old_w);
    due_q[ch].push_back(c + lat_of(g));
  endfunction

  // ---------------- driver ----------------
  task automatic op(input bit ea, input logic [NBE-1:0] wa, input logic [WADDR-1:0] aa,
                    input logic [WDATA-1:0] da,
                    input bit eb, input logic [NBE-1:0] wb, input logic [WADDR-1:0] ab,
                    input logic [WDATA-1:0] db);
    int c = cyc;
    bit a_en = ea && !busy_model(c);
    bit b_en = eb && !busy_model(c);
    bit a_wr = a_en && (wa != '0);
    bit b_wr = b_en && (wb != '0);
    logic [WDATA-1:0] old_a = model_mem[aa];
    logic [WDATA-1:0] old_b = model_mem[ab];
    ena = ea; wea = wa; addra = aa; dia = da;
    enb = eb; web = wb; addrb = ab; dib = db;
    // Port A is applied last so it owns lanes both ports write.
    for (int i = 0; i < NBE; i++) if (b_wr && wb[i]) model_mem[ab][i*WBYTE +: WBYTE] = db[i*WBYTE +: WBYTE];
    for (int i = 0; i < NBE; i++) if (a_wr && wa[i]) model_mem[aa][i*WBYTE +: WBYTE] = da[i*WBYTE +: WBYTE];
    for (int g = 0; g < NI; g++) begin
      expect_port(2*g,   g, a_en, a_wr, old_a, model_mem[aa], c);
      expect_port(2*g+1, g, b_en, b_wr, old_b, model_mem[ab], c);
    end
    if (a_en && b_en && aa == ab && (a_wr || b_wr)) exp_col[c+1] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) op(0, '0, '0, '0, 0, '0, '0, '0);
  endtask

  task automatic rand_op();
    logic [WADDR-1:0] aa = WADDR'($urandom_range(0, DEPTH-1));
    logic [WADDR-1:0] ab = ($urandom_range(0, 2) == 0) ? aa : WADDR'($urandom_range(0, DEPTH-1));
    logic [NBE-1:0]   wa = ($urandom_range(0, 1) == 0) ? '0 : NBE'($urandom_range(0, 15));
    logic [NBE-1:0]   wb = ($urandom_range(0, 1) == 0) ? '0 : NBE'($urandom_range(0, 15));
    op($urandom_range(0, 3) != 0, wa, aa, $urandom,
       $urandom_range(0, 3) != 0, wb, ab, $urandom);
  endtask

  // Assert reset right after an edge and check the outputs clear without a clock.
  task automatic do_reset(input int hold);
    rst = 1'b1;
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("rst_doa", doa[g], 32'h0);
      chk("rst_dob", dob[g], 32'h0);
      chk("rst_valid", {30'h0, valida[g], validb[g]}, 32'h0);
      chk("rst_collision", 32'(col[g]), 32'h0);
      chk("rst_busy", 32'(busy[g]), 32'h1);
    end
    repeat (hold) @(posedge clk);
    #1;
    rst     = 1'b0;
    rel_cyc = cyc;
    for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
  endtask

  // ---------------- monitor ----------------
  function automatic void check_port(int ch, logic v, logic [WDATA-1:0] d);
    if (v) begin
      if (exp_q[ch].size() == 0) begin
        chk($sformatf("unexpected_valid_ch%0d", ch), 32'h1, 32'h0);
      end else begin
        last_exp[ch] = exp_q[ch].pop_front();
        chk($sformatf("rd_data_ch%0d", ch), d, last_exp[ch]);
        chk($sformatf("rd_latency_ch%0d", ch), 32'(cyc), 32'(due_q[ch].pop_front()));
      end
    end else begin
      if (due_q[ch].size() != 0 && due_q[ch][0] <= cyc) begin
        chk($sformatf("missing_valid_ch%0d", ch), 32'h0, 32'h1);
        void'(exp_q[ch].pop_front());
        void'(due_q[ch].pop_front());
      end
      chk($sformatf("hold_ch%0d", ch), d, last_exp[ch]);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        exp_q[ch].delete();
        due_q[ch].delete();
        last_exp[ch] = '0;
      end
    end else begin
      for (int g = 0; g < NI; g++) begin
        chk($sformatf("init_busy_%0d", g), 32'(busy[g]), 32'(busy_model(cyc)));
        chk($sformatf("collision_%0d", g), 32'(col[g]), 32'(exp_col.exists(cyc)));
        check_port(2*g,   valida[g], doa[g]);
        check_port(2*g+1, validb[g], dob[g]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    ena = 0; enb = 0; wea = '0; web = '0;
    addra = '0; addrb = '0; dia = '0; dib = '0;
    for (int ch = 0; ch < NCH; ch++) last_exp[ch] = '0;
    #1;
    do_reset(2);

    // Accesses during the clear sweep must be ignored.
    op(1, 4'hF, 4'd2, 32'h12345678, 1, '0, 4'd2, '0);
    op(1, '0, 4'd9, '0, 1, 4'hF, 4'd9, 32'h87654321);
    while (busy_model(cyc)) idle(1);

    // Every location reads back zero after the sweep.
    for (int a = 0; a < DEPTH; a++) op(1, '0, WADDR'(a), '0, 1, '0, WADDR'(DEPTH-1-a), '0);

    // Write on A, read back on B and A.
    op(1, 4'hF, 4'd5, 32'hDEADBEEF, 0, '0, '0, '0);
    op(0, '0, '0, '0, 1, '0, 4'd5, '0);
    op(1, '0, 4'd5, '0, 0, '0, '0, '0);
    idle(2);

    // Byte lanes.
    op(1, 4'hF, 4'd6, 32'h11223344, 0, '0, '0, '0);
    op(1, 4'h5, 4'd6, 32'hAABBCCDD, 0, '0, '0, '0);
    op(0, '0, '0, '0, 1, '0, 4'd6, '0);
    idle(2);

    // Same-port read-during-write.
    op(1, 4'hF, 4'd3, 32'h1, 0, '0, '0, '0);
    op(1, 4'hF, 4'd3, 32'h2, 0, '0, '0, '0);
    op(0, '0, 4'd0, '0, 1, 4'h3, 4'd4, 32'h0000ABCD);
    idle(2);

    // Write/write collision, then read/write and write/read collisions.
    op(1, 4'hF, 4'd7, 32'h12345678, 0, '0, '0, '0);
    op(1, 4'hC, 4'd7, 32'hAAAA0000, 1, 4'hE, 4'd7, 32'h0000BBBB);
    op(1, '0, 4'd7, '0, 1, 4'hF, 4'd7, 32'hCAFEF00D);
    op(1, 4'h1, 4'd7, 32'h000000EE, 1, '0, 4'd7, '0);
    op(1, '0, 4'd7, '0, 1, '0, 4'd7, '0);
    idle(3);

    for (int k = 0; k < 400; k++) rand_op();
    idle(4);

    // Reset while outputs hold data, then again mid-sweep at counter 9.
    do_reset(2);
    while (cyc < rel_cyc + 9) rand_op();
    do_reset(1);
    for (int k = 0; k < 250; k++) rand_op();
    idle(5);

    for (int ch = 0; ch < NCH; ch++) chk($sformatf("drain_ch%0d", ch), 32'(exp_q[ch].size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
